// File: rtl/matrix_pkg.sv
// Shared matrix geometry, size codes and loader state for the loader and determinant ALU.
package matrix_pkg;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;

    localparam logic [2:0] SIZE_2X2 = 3'b010;
    localparam logic [2:0] SIZE_3X3 = 3'b011;
    localparam logic [2:0] SIZE_4X4 = 3'b100;
    localparam logic [2:0] SIZE_5X5 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } loader_state_e;

    function automatic logic size_valid(input logic [2:0] size_code);
        return (size_code >= SIZE_2X2) && (size_code <= SIZE_5X5);
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Host-side byte stream plus consumer-side matrix handoff for matrix_loader.
interface matrix_loader_if;

    logic                        start;
    logic [2:0]                  matrix_size;
    logic [matrix_pkg::ELEM_W-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [matrix_pkg::FLAT_W-1:0] A_flat;
    logic [2:0]                  size_out;
    logic                        matrix_valid;
    logic                        matrix_ack;
    logic                        busy;
    logic                        size_error;

    modport master (
        output start, matrix_size, in_data, in_valid, matrix_ack,
        input  in_ready, A_flat, size_out, matrix_valid, busy, size_error
    );

    modport slave (
        input  start, matrix_size, in_data, in_valid, matrix_ack,
        output in_ready, A_flat, size_out, matrix_valid, busy, size_error
    );

endinterface

// File: rtl/matrix_index_counter.sv
// Row/col walker over an N x N matrix; last_o flags the (N-1,N-1) position.
module matrix_index_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [2:0] n_i,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic       last_o
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] n_m1;

    assign n_m1 = n_i - 3'd1;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (load_i) begin
            row_d = 3'd0;
            col_d = 3'd0;
        end else if (en_i) begin
            if (col_q == n_m1) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == n_m1) && (col_q == n_m1);

endmodule

// File: rtl/matrix_loader.sv
// Packs a byte stream into a zero-padded 5x5 flat matrix and holds it until acked.
// Define LOADER_TRANSPOSE_EN to place each byte at (col,row), accepting column-major input.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    matrix_loader_if.slave  bus
);

    loader_state_e     state_q, state_d;
    logic [FLAT_W-1:0] a_flat_q, a_flat_d;
    logic [2:0]        size_q, size_d;
    logic              matrix_valid_q;
    logic              busy_q;
    logic              size_error_q, size_error_d;

    logic              in_ready;
    logic              xfer;
    logic              cnt_load;
    logic              last;
    logic [2:0]        row, col;
    logic [4:0]        wr_idx;

    assign in_ready = (state_q == ST_LOAD);
    assign xfer     = bus.in_valid && in_ready;

    matrix_index_counter u_idx (
        .clock  (clock),
        .reset  (reset),
        .load_i (cnt_load),
        .en_i   (xfer),
        .n_i    (size_q),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

`ifdef LOADER_TRANSPOSE_EN
    assign wr_idx = 5'(col) * 5'(MAX_DIM) + 5'(row);
`else
    assign wr_idx = 5'(row) * 5'(MAX_DIM) + 5'(col);
`endif

    always_comb begin
        state_d      = state_q;
        a_flat_d     = a_flat_q;
        size_d       = size_q;
        size_error_d = 1'b0;
        cnt_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (size_valid(bus.matrix_size)) begin
                        state_d  = ST_LOAD;
                        size_d   = bus.matrix_size;
                        a_flat_d = '0;
                        cnt_load = 1'b1;
                    end else begin
                        size_error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    for (int p = 0; p < MAX_DIM * MAX_DIM; p++) begin
                        if (wr_idx == 5'(p)) begin
                            a_flat_d[p*ELEM_W +: ELEM_W] = bus.in_data;
                        end
                    end
                    if (last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A start arriving with the ack is dropped: start is only sampled in IDLE.
                if (bus.matrix_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            a_flat_q       <= '0;
            size_q         <= 3'd0;
            matrix_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            size_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_flat_q       <= a_flat_d;
            size_q         <= size_d;
            matrix_valid_q <= (state_d == ST_HOLD);
            busy_q         <= (state_d != ST_IDLE);
            size_error_q   <= size_error_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.A_flat       = a_flat_q;
    assign bus.size_out     = size_q;
    assign bus.matrix_valid = matrix_valid_q;
    assign bus.busy         = busy_q;
    assign bus.size_error   = size_error_q;

endmodule
